mem_responder: RTL

- Memory-side responder for the rv32i multicycle core's memory port. The core is the initiator: it drives mem_read/mem_write, mem_address, mem_wdata and mem_byte_enable.
- The block models a word-organised SRAM with a programmable response latency. It returns mem_rdata and a one-cycle mem_resp per request.
- It sits between the core and the testbench in place of the behavioural memory. It is synthesizable and reports out-of-range or malformed requests.

---
 rtl/mem_responder_if.sv | 29 ++
 rtl/mem_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Memory port bundle between the rv32i core (master) and a memory-side
// responder (slave).
//   mem_read / mem_write  : request kind, held by the master until mem_resp
//   mem_byte_enable[3:0]  : write byte lanes, bit i selects mem_wdata[8i+7:8i]
//   mem_address[31:0]     : byte address, bits [1:0] ignored by the responder
//   mem_wdata[31:0]       : write data
//   mem_rdata[31:0]       : read data, valid while mem_resp is high
//   mem_resp              : one-cycle completion pulse
//   mem_err               : error flag, valid only while mem_resp is high
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        mem_err;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp, mem_err
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp, mem_err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-organised SRAM model with programmable response latency, answering the
// rv32i multicycle core's memory port.
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-low reset; clears the array and abandons any
//          in-flight request
//   bus  : mem_responder_if.slave (request in, mem_rdata/mem_resp/mem_err out)
// A request is latched in IDLE and answered with a one-cycle mem_resp in the
// LATENCY-th cycle after the sampling edge. Out-of-range addresses and
// simultaneous read+write complete with mem_err=1, mem_rdata=0 and no update.
module mem_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 3
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;
    logic                   write_q, write_d;
    logic                   err_q, err_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   resp_q, resp_d;
    logic                   mem_err_q, mem_err_d;
    logic [31:0]            mem_q [DEPTH];

    logic                   enter_resp_s;
    logic                   wr_en_s;
    logic [ADDR_BITS-1:0]   idx_s;
    logic [31:0]            cur_word_s;
    logic [31:0]            wr_word_s;

    // Next-state, request latching and completion actions.
    // The transaction fields are taken from the *_d values so that LATENCY=1,
    // where sampling and completion share one edge, uses the live inputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        write_d      = write_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        resp_d       = 1'b0;
        mem_err_d    = 1'b0;
        enter_resp_s = 1'b0;
        wr_en_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    addr_d  = bus.mem_address;
                    wdata_d = bus.mem_wdata;
                    be_d    = bus.mem_byte_enable;
                    write_d = bus.mem_write;
                    err_d   = ((bus.mem_address >> (ADDR_BITS + 2)) != 32'd0) ||
                              (bus.mem_read && bus.mem_write);
                    if (LATENCY <= 1) begin
                        state_d      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        idx_s      = addr_d[ADDR_BITS+1:2];
        cur_word_s = mem_q[idx_s];

        if (enter_resp_s) begin
            resp_d = 1'b1;
            if (err_d) begin
                rdata_d   = 32'd0;
                mem_err_d = 1'b1;
            end else if (write_d) begin
                wr_en_s = 1'b1;
            end else begin
                rdata_d = cur_word_s;
            end
        end else begin
            resp_d = 1'b0;
        end
    end

    // Byte-lane merge of the write data over the addressed word.
    always_comb begin
        wr_word_s = cur_word_s;
        for (int i = 0; i < 4; i++) begin
            if (be_d[i]) begin
                wr_word_s[8*i +: 8] = wdata_d[8*i +: 8];
            end else begin
                wr_word_s[8*i +: 8] = cur_word_s[8*i +: 8];
            end
        end
    end

    // Control state, latched request fields and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            resp_q    <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            write_q   <= write_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Storage array; cleared by reset, written only on a clean write completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            mem_q[idx_s] <= wr_word_s;
        end else begin
            mem_q[idx_s] <= mem_q[idx_s];
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_resp  = resp_q;
    assign bus.mem_err   = mem_err_q;
endmodule
